// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment codes, capture FSM states and select helpers shared by the display driver and monitor.
package seven_segment_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [3:0] SEG_INVALID = 4'hF;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  function automatic logic [1:0] sel_index(input logic [3:0] s);
    return s[3] ? 2'd3 : s[2] ? 2'd2 : s[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/seven_segment_capture_decode.sv
// seven_segment_decode: active-high g..a pattern to nibble; A-F accepted when SEVEN_SEGMENT_CAPTURE_HEX_EN is defined.
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);
  always_comb begin
    nibble = SEG_INVALID;
    invalid = 1'b0;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_EN
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
`endif
      default: invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: monitors a multiplexed active-low seven-segment bus and rebuilds the BCD digit vector.
// Hex digits A-F are decoded only when SEVEN_SEGMENT_CAPTURE_HEX_EN is defined.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    io_sel,
  input  logic [7:0]                    io_seg,
  output logic [NUMBER_OF_DIGITS*4-1:0] number,
  output logic [NUMBER_OF_DIGITS-1:0]   dp,
  output logic [NUMBER_OF_DIGITS-1:0]   digit_valid,
  output logic                          frame_valid,
  output logic                          bad_pattern
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  logic [3:0] sel_m, sel_s, held_sel, s;
  logic [7:0] seg_m, seg_s, held_seg;
  logic [6:0] pattern;
  logic [1:0] hk;
  logic multi, valid, changed, hit, load, capture, invalid;
  logic [3:0] nibble, seen, dv_r, dp_r;
  logic [15:0] num_r;
  logic [CW-1:0] cnt;
  state_t state, nstate;
  assign s = ~sel_s;
  assign multi = |(s & (s - 4'd1));
  assign valid = (s != 4'd0) && !multi && (32'(sel_index(s)) < NUMBER_OF_DIGITS);
  assign changed = {sel_s, seg_s} != {held_sel, held_seg};
  assign hit = cnt == CW'(SETTLE_CYCLES - 1);
  assign hk = sel_index(~held_sel);
  assign pattern = ~held_seg[6:0];
  assign number = num_r[NUMBER_OF_DIGITS*4-1:0];
  assign dp = dp_r[NUMBER_OF_DIGITS-1:0];
  assign digit_valid = dv_r[NUMBER_OF_DIGITS-1:0];

  seven_segment_decode u_decode (
    .pattern(pattern),
    .nibble (nibble),
    .invalid(invalid)
  );

  always_ff @(posedge clk) state <= rst ? IDLE : nstate;

  always_comb begin
    nstate = state;
    if (state == IDLE || changed) nstate = valid ? SETTLE : IDLE;
    else if (state == SETTLE && hit) nstate = HOLD;
  end

  always_comb begin
    load = (state == IDLE || changed) && valid;
    capture = state == SETTLE && !changed && hit;
  end

  // Capture always uses the held sample, so a change landing on the capture edge only starts the next settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m <= '1;
      sel_s <= '1;
      seg_m <= '1;
      seg_s <= '1;
      held_sel <= '1;
      held_seg <= '1;
      cnt <= '0;
      num_r <= '0;
      dp_r <= '0;
      dv_r <= '0;
      seen <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      {sel_s, sel_m} <= {sel_m, io_sel};
      {seg_s, seg_m} <= {seg_m, io_seg};
      frame_valid <= capture && seen[hk];
      if (load) begin
        held_sel <= sel_s;
        held_seg <= seg_s;
      end
      cnt <= load ? CW'(1) : (state == SETTLE && !changed) ? cnt + CW'(1) : cnt;
      if (multi || (capture && invalid)) bad_pattern <= 1'b1;
      if (capture) begin
        num_r[{hk, 2'b00} +: 4] <= nibble;
        dp_r[hk] <= ~held_seg[7];
        seen <= seen[hk] ? 4'd1 << hk : seen | (4'd1 << hk);
        if (seen[hk]) dv_r <= seen;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: scoreboard bench for seven_segment_capture; honours SEVEN_SEGMENT_CAPTURE_HEX_EN.
module tb_seven_segment_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] io_sel = 4'hF;
  logic [7:0] io_seg = 8'hFF;
  logic [15:0] number;
  logic [3:0] dp, digit_valid;
  logic frame_valid, bad_pattern;

  seven_segment_capture #(.NUMBER_OF_DIGITS(4), .SETTLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_sel     (io_sel),
    .io_seg     (io_seg),
    .number     (number),
    .dp         (dp),
    .digit_valid(digit_valid),
    .frame_valid(frame_valid),
    .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dp;
    logic [3:0]  dv;
    logic        fv;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, fv_seen = 0, fv_exp = 0;
  logic [15:0] m_num;
  logic [3:0] m_dp, m_seen, m_dv;
  logic m_bad;
  logic [11:0] m_last;

  always @(negedge clk) if (!rst && frame_valid) fv_seen++;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // {invalid, nibble}
  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h00;
      7'h06: return 5'h01;
      7'h5B: return 5'h02;
      7'h4F: return 5'h03;
      7'h66: return 5'h04;
      7'h6D: return 5'h05;
      7'h7D: return 5'h06;
      7'h07: return 5'h07;
      7'h7F: return 5'h08;
      7'h6F: return 5'h09;
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_EN
      7'h77: return 5'h0A;
      7'h7C: return 5'h0B;
      7'h39: return 5'h0C;
      7'h5E: return 5'h0D;
      7'h79: return 5'h0E;
      7'h71: return 5'h0F;
`endif
      default: return 5'h1F;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input logic [6:0] p, input logic dp_on);
    return ~{dp_on, p};
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    io_sel = 4'hF;
    io_seg = 8'hFF;
    @(posedge clk);
    #1;
    check("reset", {number, dp, digit_valid, frame_valid, bad_pattern}, 0);
    rst = 1'b0;
    m_num = '0;
    m_dp = '0;
    m_seen = '0;
    m_dv = '0;
    m_bad = 1'b0;
    m_last = 12'hFFF;
  endtask

  // Drives a value just after an edge and holds it for cyc edges (that edge included).
  task automatic apply(input logic [3:0] sel, input logic [7:0] seg, input int cyc);
    logic [3:0] s;
    logic [4:0] d;
    logic [15:0] old_num;
    logic [3:0] old_dp;
    logic cap;
    int k;
    exp_t e, g;
    s = ~sel;
    @(posedge clk);
    #1;
    io_sel = sel;
    io_seg = seg;
    cap = ({sel, seg} != m_last) && $onehot(s) && cyc >= 19;
    m_last = {sel, seg};
    if ($countones(s) > 1) m_bad = 1'b1;
    if (!cap) begin
      repeat (cyc - 1) @(posedge clk);
      #1;
      check("hold_num", number, m_num);
      check("hold_dp", dp, m_dp);
    end else begin
      k = 0;
      for (int i = 0; i < 4; i++) if (s[i]) k = i;
      d = ref_dec(~seg[6:0]);
      old_num = m_num;
      old_dp = m_dp;
      e.fv = m_seen[k];
      if (m_seen[k]) begin
        m_dv = m_seen;
        m_seen = 4'd1 << k;
        fv_exp++;
      end else m_seen[k] = 1'b1;
      m_num[4*k +: 4] = d[3:0];
      m_dp[k] = ~seg[7];
      if (d[4]) m_bad = 1'b1;
      e.num = m_num;
      e.dp = m_dp;
      e.dv = m_dv;
      sb.push_back(e);
      repeat (17) @(posedge clk);
      #1;
      check("pre_capture_num", number, old_num);
      check("pre_capture_dp", dp, old_dp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        g = sb.pop_front();
        check("cap_num", number, g.num);
        check("cap_dp", dp, g.dp);
        check("cap_dv", digit_valid, g.dv);
        check("cap_fv", frame_valid, g.fv);
      end
      @(posedge clk);
      #1;
      check("fv_one_cycle", frame_valid, 0);
      repeat (cyc - 20) @(posedge clk);
    end
    #1;
    check("bad", bad_pattern, m_bad);
  endtask

  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  initial begin
    do_reset();
    // Two passes showing 1,2,3,4 on digits 0..3
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 4; i++) apply(~(4'd1 << i), seg_of(PAT[i+1], 1'b0), 100);
    check("scan_num", number, 16'h4321);
    check("scan_dv", digit_valid, 4'hF);
    check("scan_bad", bad_pattern, 0);
    // Latency: digit 2 with dp on digit 0
    apply(4'b1110, 8'h24, 40);
    check("lat_nibble", number[3:0], 4'h2);
    check("lat_dp", dp[0], 1'b1);
    // Short glitch, then back to the held value
    apply(4'b1110, seg_of(7'h7F, 1'b0), 10);
    check("glitch_num", number, m_num);
    apply(4'b1110, 8'h24, 40);
    check("glitch_nibble", number[3:0], 4'h2);
    // Hex pattern on digit 1
    apply(4'b1101, seg_of(7'h77, 1'b0), 40);
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_EN
    check("hex_nibble", number[7:4], 4'hA);
    check("hex_bad", bad_pattern, 0);
`else
    check("hex_nibble", number[7:4], 4'hF);
    check("hex_bad", bad_pattern, 1);
`endif
    // Two selects low at once
    do_reset();
    apply(4'b1100, seg_of(7'h3F, 1'b0), 50);
    check("multi_bad", bad_pattern, 1);
    check("multi_num", number, 0);
    // Digit 3 blanked, reset mid-settle, rescan
    do_reset();
    for (int i = 0; i < 3; i++) apply(~(4'd1 << i), seg_of(PAT[i+5], 1'b1), 40);
    apply(4'hF, 8'hFF, 40);
    apply(4'b1110, seg_of(PAT[8], 1'b0), 8);
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) apply(~(4'd1 << i), seg_of(PAT[i+1], 1'b0), 40);
      apply(4'hF, 8'hFF, 40);
    end
    apply(4'b1110, seg_of(PAT[9], 1'b0), 40);
    check("blank_dv", digit_valid, 4'b0111);
    check("fv_count", fv_seen, fv_exp);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side counterpart of the multiplexed seven-segment display driver. It watches the active-low digit-select and segment bus, waits for each select to settle, and decodes the segment pattern back into BCD. It then rebuilds the per-digit number vector and flags the end of each scan frame. It sits on the board-level display bus as a self-check and loopback monitor, and in benches as the display scoreboard front end.

## Interface
- NUMBER_OF_DIGITS, 4, digits captured; must be 1..4, since io_sel is 4 bits.
- SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a capture; minimum 2.
- clk  input  1  board clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- io_sel  input  4  digit select, active-low, one-hot; bit i selects digit i.
- io_seg  input  8  segments, active-low; [0]=a … [6]=g, [7]=dp.
- number  output  NUMBER_OF_DIGITS*4  decoded digits; digit i occupies bits [4i+3:4i].
- dp  output  NUMBER_OF_DIGITS  decimal point per digit, active-high.
- digit_valid  output  NUMBER_OF_DIGITS  digits seen in the last completed frame.
- frame_valid  output  1  one-cycle pulse when a scan frame completes.
- bad_pattern  output  1  sticky flag: an undecodable segment pattern, or more than one select low; cleared only by rst.

## Operation
- io_sel and io_seg pass through a 2-flop synchronizer before any logic.
- Select decode uses the inverted sync select, s = ~io_sel_sync:
  - s == 0: blank; no digit is addressed.
  - exactly one bit set, with index < NUMBER_OF_DIGITS: valid index.
  - more than one bit set: sets bad_pattern; no capture.
  - one bit set with index ≥ NUMBER_OF_DIGITS: ignored.
- State machine:
  - IDLE: waits for a valid index, then goes to SETTLE with cnt=1.
  - SETTLE: increments cnt while {sel,seg} is unchanged. Any change restarts cnt=1, or returns to IDLE if the new select is not valid. When cnt reaches SETTLE_CYCLES, capture and go to HOLD.
  - HOLD: waits for any change of {sel,seg}, then re-evaluates as from IDLE.
- Segment decode uses p = ~io_seg_sync[6:0], active-high g..a:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - Any other pattern stores 4'hF and sets bad_pattern.
- A capture of digit k writes number[4k+3:4k] and dp[k] = ~io_seg_sync[7].
- Frame tracking uses an internal seen mask:
  - If bit k is already set in seen, the scan has wrapped: pulse frame_valid, load digit_valid ← seen, then set seen ← (1<<k).
  - Otherwise set seen[k].
  - Blanked digits therefore never appear in digit_valid.
- Reset values: number=0, dp=0, digit_valid=0, frame_valid=0, bad_pattern=0, seen=0, state=IDLE, cnt=0.

## Timing
- Latency: an input change at edge 0, held stable, updates number and dp at edge SETTLE_CYCLES+2, visible after that edge.
- frame_valid asserts in the same cycle as the wrapping capture's number update, and lasts exactly one cycle.
- An input change arriving on the capture edge does not corrupt the capture, which uses the held value; the next cycle begins settling the new value.
- A glitch shorter than SETTLE_CYCLES causes no capture and leaves outputs unchanged.
- rst asserted mid-SETTLE or mid-HOLD returns all outputs to reset values at the next edge. The synchronizer flops also clear to all-ones, meaning idle and blank.

## Configuration
- SEVEN_SEGMENT_CAPTURE_HEX_EN:
  - Defined: additionally decodes 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F, with no bad_pattern for these.
  - Undefined: these six patterns store 4'hF and set bad_pattern.

## Structure
- Shared package seven_segment_pkg holds:
  - the segment code constants for 0–9 and A–F (active-high g..a), shared with the driver-side BCD decoder;
  - the state enum IDLE/SETTLE/HOLD;
  - the SEG_INVALID = 4'hF constant.
- One natural sub-module: seven_segment_decode, combinational pattern → {nibble, invalid}, with HEX_EN handled inside it.

## Test plan
- Scan digits 0..3 showing 1,2,3,4, 100 cycles each, SETTLE_CYCLES=16 -> after the second pass number=16'h4321, digit_valid=4'hF, one frame_valid per wrap, bad_pattern=0.
- io_sel=4'b1110 with 0x24 on io_seg[6:0] (digit 2) and dp bit low -> number[3:0]=2 and dp[0]=1 exactly 18 cycles after the change.
- 10-cycle glitch of io_seg to ~7F on a held digit -> no change to number.
- io_sel=4'b1100 held 50 cycles -> bad_pattern=1; no capture.
- Pattern 77 on digit 1 -> HEX_EN defined: number[7:4]=A, bad_pattern=0; undefined: number[7:4]=F, bad_pattern=1.
- Digit 3 blanked (io_sel=4'hF slot), rst pulsed mid-SETTLE -> all outputs 0 next cycle; after rescan digit_valid=4'b0111.
